// File: rtl/game_mem_pkg.sv
// Shared constants for the game-board memory: FSM encoding, default geometry
// and the collision counter width.
package game_mem_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 8;
  localparam int COLL_CNT_W = 16;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/game_board_mem_if.sv
// One request/ready access port of the game-board memory; the controller side
// uses the master modport, the memory uses the slave modport.
interface game_board_mem_if
  import game_mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              req;
  logic              ready;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic [DATA_W-1:0] q;
  logic              rvalid;

  modport master (
    output req, we, addr, data,
    input  ready, q, rvalid
  );

  modport slave (
    input  req, we, addr, data,
    output ready, q, rvalid
  );

endinterface

// File: rtl/game_board_ram_dp.sv
// True dual-port word array with registered, read-before-write outputs.
// When both ports write one address in the same cycle, port A wins.
module game_board_ram_dp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_a,
  input  logic              rd_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] wdata_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic              we_b,
  input  logic              rd_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] wdata_b,
  output logic [DATA_W-1:0] rdata_b
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [0:DEPTH-1];
  logic              b_blocked;

  assign b_blocked = we_a && (addr_a == addr_b);

  always_ff @(posedge clk) begin
    if (we_a)
      mem[addr_a] <= wdata_a;
    if (we_b && !b_blocked)
      mem[addr_b] <= wdata_b;
  end

  // Non-blocking reads sample the array before this edge's writes land.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_a <= '0;
      rdata_b <= '0;
    end else begin
      if (rd_a)
        rdata_a <= mem[addr_a];
      if (rd_b)
        rdata_b <= mem[addr_b];
    end
  end

endmodule

// File: rtl/game_board_mem.sv
// Dual-port game-board memory with clear sequencer, handshake and collision flag.
// Define GAME_MEM_COLLISION_CNT_EN to add the saturating collision_cnt output.
module game_board_mem
  import game_mem_pkg::*;
#(
  parameter int                DATA_W     = DEF_DATA_W,
  parameter int                ADDR_W     = DEF_ADDR_W,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  clear_req,
  output logic                  busy,
  game_board_mem_if.slave       port_a,
  game_board_mem_if.slave       port_b,
  output logic                  collision
`ifdef GAME_MEM_COLLISION_CNT_EN
  ,
  output logic [COLL_CNT_W-1:0] collision_cnt
`endif
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t            state_reg;
  state_t            state_next;
  logic [ADDR_W-1:0] clr_addr_reg;
  logic              ready;

  logic              wr_a, rd_a, wr_b, rd_b;
  logic              coll_next;
  logic              rvalid_a_reg, rvalid_b_reg, collision_reg;

  logic              ram_we_a;
  logic [ADDR_W-1:0] ram_addr_a;
  logic [DATA_W-1:0] ram_wdata_a;
  logic [DATA_W-1:0] q_a, q_b;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      state_reg <= ST_CLEAR;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_CLEAR: if (clr_addr_reg == LAST_ADDR) state_next = ST_RUN;
      ST_RUN:   if (clear_req)                 state_next = ST_CLEAR;
      default:                                 state_next = ST_CLEAR;
    endcase
  end

  always_comb begin
    busy  = (state_reg == ST_CLEAR);
    ready = (state_reg == ST_RUN);
  end

  // The sweep counter wraps to 0 on its last write, so it is already at 0
  // the next time a clear starts.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      clr_addr_reg <= '0;
    else if (state_reg == ST_CLEAR)
      clr_addr_reg <= clr_addr_reg + 1'b1;
    else
      clr_addr_reg <= '0;
  end

  assign wr_a = port_a.req && ready && port_a.we;
  assign rd_a = port_a.req && ready && !port_a.we;
  assign wr_b = port_b.req && ready && port_b.we;
  assign rd_b = port_b.req && ready && !port_b.we;

  assign coll_next = wr_a && wr_b && (port_a.addr == port_b.addr);

  // The clear sweep borrows port A's write path; ready is low meanwhile.
  assign ram_we_a    = busy ? 1'b1         : wr_a;
  assign ram_addr_a  = busy ? clr_addr_reg : port_a.addr;
  assign ram_wdata_a = busy ? INIT_VALUE   : port_a.data;

  game_board_ram_dp #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clock),
    .rst_n   (resetn),
    .we_a    (ram_we_a),
    .rd_a    (rd_a),
    .addr_a  (ram_addr_a),
    .wdata_a (ram_wdata_a),
    .rdata_a (q_a),
    .we_b    (wr_b),
    .rd_b    (rd_b),
    .addr_b  (port_b.addr),
    .wdata_b (port_b.data),
    .rdata_b (q_b)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rvalid_a_reg  <= 1'b0;
      rvalid_b_reg  <= 1'b0;
      collision_reg <= 1'b0;
    end else begin
      rvalid_a_reg  <= rd_a;
      rvalid_b_reg  <= rd_b;
      collision_reg <= coll_next;
    end
  end

  assign port_a.ready  = ready;
  assign port_a.q      = q_a;
  assign port_a.rvalid = rvalid_a_reg;
  assign port_b.ready  = ready;
  assign port_b.q      = q_b;
  assign port_b.rvalid = rvalid_b_reg;
  assign collision     = collision_reg;

`ifdef GAME_MEM_COLLISION_CNT_EN
  logic [COLL_CNT_W-1:0] coll_cnt_reg;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      coll_cnt_reg <= '0;
    else if (state_reg == ST_RUN && state_next == ST_CLEAR)
      coll_cnt_reg <= '0;
    else if (coll_next && coll_cnt_reg != '1)
      coll_cnt_reg <= coll_cnt_reg + 1'b1;
  end

  assign collision_cnt = coll_cnt_reg;
`endif

endmodule

// File: tb/tb_game_board_mem.sv
// Directed bench: a 16-word instance exercises sweep/clear/reset timing, a
// 256-word instance exercises data transfers and collision rules.
module tb_game_board_mem;

  localparam logic [31:0] S_INIT = 32'hC0DE_0001;

  logic clk;
  logic rst_s, rst_l;
  logic clear_s, clear_l;
  logic busy_s, busy_l;
  logic coll_s, coll_l;

  int compared   = 0;
  int mismatched = 0;

  game_board_mem_if #(.DATA_W(32), .ADDR_W(4)) sa ();
  game_board_mem_if #(.DATA_W(32), .ADDR_W(4)) sb ();
  game_board_mem_if #(.DATA_W(32), .ADDR_W(8)) la ();
  game_board_mem_if #(.DATA_W(32), .ADDR_W(8)) lb ();

  game_board_mem #(.DATA_W(32), .ADDR_W(4), .INIT_VALUE(S_INIT)) dut_s (
    .clock     (clk),
    .resetn    (rst_s),
    .clear_req (clear_s),
    .busy      (busy_s),
    .port_a    (sa),
    .port_b    (sb),
    .collision (coll_s)
  );

  game_board_mem #(.DATA_W(32), .ADDR_W(8), .INIT_VALUE(32'h0)) dut_l (
    .clock     (clk),
    .resetn    (rst_l),
    .clear_req (clear_l),
    .busy      (busy_l),
    .port_a    (la),
    .port_b    (lb),
    .collision (coll_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    $display("chk %s observed=%0h expected=%0h", tag, obs, exp);
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int n;
    rst_s = 1'b0; rst_l = 1'b0; clear_s = 1'b0; clear_l = 1'b0;
    sa.req = 0; sa.we = 0; sa.addr = '0; sa.data = '0;
    sb.req = 0; sb.we = 0; sb.addr = '0; sb.data = '0;
    la.req = 0; la.we = 0; la.addr = '0; la.data = '0;
    lb.req = 0; lb.we = 0; lb.addr = '0; lb.data = '0;
    tick();
    tick();

    // Reset state
    check("rst_busy",     64'(busy_s), 64'd1);
    check("rst_ready_a",  64'(sa.ready), 64'd0);
    check("rst_ready_b",  64'(sb.ready), 64'd0);
    check("rst_q_a",      64'(sa.q), 64'd0);
    check("rst_rvalid_a", 64'(sa.rvalid), 64'd0);
    check("rst_coll",     64'(coll_s), 64'd0);

    // Release: 16-cycle sweep with requests that must be ignored
    rst_s = 1'b1; rst_l = 1'b1;
    sa.req = 1; sa.we = 1; sa.addr = 4'h3; sa.data = 32'h0000_00AB;
    sb.req = 1; sb.we = 0; sb.addr = 4'h3;
    check("sweep_busy_0", 64'(busy_s), 64'd1);
    for (int i = 1; i < 16; i++) begin
      tick();
      check("sweep_busy", 64'(busy_s), 64'd1);
      check("sweep_ready_a", 64'(sa.ready), 64'd0);
      check("sweep_ready_b", 64'(sb.ready), 64'd0);
      check("sweep_rvalid_b", 64'(sb.rvalid), 64'd0);
    end
    sa.req = 0; sb.req = 0;
    tick();
    check("sweep_done_busy", 64'(busy_s), 64'd0);
    check("sweep_done_ready", 64'(sa.ready), 64'd1);

    // Large instance: 256-cycle sweep, 16 edges already elapsed
    n = 0;
    while (busy_l && n < 400) begin
      tick();
      n++;
    end
    check("big_sweep_len", 64'(16 + n), 64'd256);

    // Ignored write left INIT_VALUE in place; both ports read
    sa.req = 1; sa.we = 0; sa.addr = 4'h3;
    sb.req = 1; sb.we = 0; sb.addr = 4'hC;
    tick();
    sa.req = 0; sb.req = 0;
    check("init_rvalid_a", 64'(sa.rvalid), 64'd1);
    check("init_q_a", 64'(sa.q), 64'(S_INIT));
    check("init_rvalid_b", 64'(sb.rvalid), 64'd1);
    check("init_q_b", 64'(sb.q), 64'(S_INIT));
    tick();
    check("init_rvalid_a_fall", 64'(sa.rvalid), 64'd0);
    check("init_q_a_hold", 64'(sa.q), 64'(S_INIT));

    // Write then read on port A
    la.req = 1; la.we = 1; la.addr = 8'h10; la.data = 32'hDEAD_BEEF;
    tick();
    check("wr_no_rvalid", 64'(la.rvalid), 64'd0);
    la.we = 0;
    tick();
    la.req = 0;
    check("rd_rvalid", 64'(la.rvalid), 64'd1);
    check("rd_q", 64'(la.q), 64'h0000_0000_DEAD_BEEF);
    tick();
    check("rd_rvalid_pulse", 64'(la.rvalid), 64'd0);
    check("rd_q_hold", 64'(la.q), 64'h0000_0000_DEAD_BEEF);

    // Same-address write collision: A wins
    la.req = 1; la.we = 1; la.addr = 8'h20; la.data = 32'h1;
    lb.req = 1; lb.we = 1; lb.addr = 8'h20; lb.data = 32'h2;
    tick();
    la.req = 0; lb.req = 0;
    check("coll_pulse", 64'(coll_l), 64'd1);
    tick();
    check("coll_clear", 64'(coll_l), 64'd0);
    la.req = 1; la.we = 0; la.addr = 8'h20;
    lb.req = 1; lb.we = 0; lb.addr = 8'h20;
    tick();
    la.req = 0; lb.req = 0;
    check("coll_q_a", 64'(la.q), 64'd1);
    check("coll_q_b", 64'(lb.q), 64'd1);
    check("coll_rvalid_b", 64'(lb.rvalid), 64'd1);

    // Different-address writes both commit
    la.req = 1; la.we = 1; la.addr = 8'h21; la.data = 32'h11;
    lb.req = 1; lb.we = 1; lb.addr = 8'h22; lb.data = 32'h22;
    tick();
    check("nocoll_pulse", 64'(coll_l), 64'd0);
    la.we = 0; lb.we = 0;
    tick();
    la.req = 0; lb.req = 0;
    check("nocoll_q_a", 64'(la.q), 64'h11);
    check("nocoll_q_b", 64'(lb.q), 64'h22);

    // Read-before-write across ports
    la.req = 1; la.we = 1; la.addr = 8'h30; la.data = 32'h5;
    tick();
    la.data = 32'h7;
    lb.req = 1; lb.we = 0; lb.addr = 8'h30;
    tick();
    la.req = 0;
    check("rbw_old", 64'(lb.q), 64'h5);
    check("rbw_coll", 64'(coll_l), 64'd0);
    tick();
    lb.req = 0;
    check("rbw_new", 64'(lb.q), 64'h7);

    // Clear request on the small instance with a read in the same cycle
    sa.req = 1; sa.we = 1; sa.addr = 4'h2; sa.data = 32'h1234;
    sb.req = 1; sb.we = 1; sb.addr = 4'h9; sb.data = 32'h5678;
    tick();
    sb.req = 0;
    sa.we = 0;
    clear_s = 1'b1;
    tick();
    sa.req = 0; clear_s = 1'b0;
    check("clr_read_rvalid", 64'(sa.rvalid), 64'd1);
    check("clr_read_q", 64'(sa.q), 64'h1234);
    check("clr_busy_0", 64'(busy_s), 64'd1);
    sb.req = 1; sb.we = 1; sb.addr = 4'h9; sb.data = 32'hFFFF;
    for (int i = 1; i < 16; i++) begin
      clear_s = (i == 8);
      tick();
      check("clr_busy", 64'(busy_s), 64'd1);
      check("clr_ready_b", 64'(sb.ready), 64'd0);
    end
    clear_s = 1'b0; sb.req = 0;
    tick();
    check("clr_done_busy", 64'(busy_s), 64'd0);
    sa.req = 1; sa.we = 0; sa.addr = 4'h2;
    sb.req = 1; sb.we = 0; sb.addr = 4'h9;
    tick();
    sa.req = 0; sb.req = 0;
    check("clr_wiped_a", 64'(sa.q), 64'(S_INIT));
    check("clr_wiped_b", 64'(sb.q), 64'(S_INIT));

    // Asynchronous reset mid-sweep, after five sweep writes
    sa.req = 1; sa.we = 0; sa.addr = 4'h3;
    clear_s = 1'b1;
    tick();
    sa.req = 0; clear_s = 1'b0;
    check("mid_q_before", 64'(sa.q), 64'(S_INIT));
    for (int i = 0; i < 5; i++) tick();
    #2;
    rst_s = 1'b0;
    #1;
    check("mid_rst_q_a", 64'(sa.q), 64'd0);
    check("mid_rst_q_b", 64'(sb.q), 64'd0);
    check("mid_rst_busy", 64'(busy_s), 64'd1);
    check("mid_rst_ready", 64'(sa.ready), 64'd0);
    check("mid_rst_coll", 64'(coll_s), 64'd0);
    tick();
    rst_s = 1'b1;
    check("mid_busy_0", 64'(busy_s), 64'd1);
    for (int i = 1; i < 16; i++) begin
      tick();
      check("mid_busy", 64'(busy_s), 64'd1);
    end
    tick();
    check("mid_done_busy", 64'(busy_s), 64'd0);
    check("mid_done_ready", 64'(sb.ready), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/game_board_mem.md
Name: game_board_mem

Overview:
- Parametrised dual-port game-board memory.
- Successor to the fixed 32-bit x 256-word dual-port game RAM wrapper.
- Adds generic width and depth, a request/ready handshake per port, registered read-valid, and deterministic same-address collision rules.
- Adds a hardware clear sequencer that wipes the board after reset or on a new-game request.
- Sits between the game controller (port A) and the display/opponent logic (port B).

Parameters:
- DATA_W, 32, word width in bits.
- ADDR_W, 8, address width; DEPTH = 2**ADDR_W words.
- INIT_VALUE, 0, word written to every location during a clear sweep (DATA_W bits).

Ports:
- clock  in  1  single system clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- clear_req  in  1  pulse: start a clear sweep (new game).
- busy  out  1  high while a clear sweep runs.
- req_a  in  1  port A request.
- ready_a  out  1  port A can accept; equals !busy.
- we_a  in  1  port A write (1) / read (0).
- addr_a  in  ADDR_W  port A address.
- data_a  in  DATA_W  port A write data.
- q_a  out  DATA_W  port A read data.
- rvalid_a  out  1  q_a valid, one-cycle pulse.
- req_b, ready_b, we_b, addr_b, data_b, q_b, rvalid_b: same as port A, for port B.
- collision  out  1  one-cycle pulse: both ports wrote the same address in the same cycle.

Behaviour:
- Reset (resetn low, asynchronous):
  - state=CLEAR, clr_addr=0, busy=1.
  - q_a=q_b=0, rvalid_a=rvalid_b=0, collision=0.
  - Array contents are not reset directly; the sweep overwrites them.
- FSM states: CLEAR, RUN.
- CLEAR:
  - Each cycle writes INIT_VALUE to mem[clr_addr], then clr_addr+1.
  - When the write to DEPTH-1 completes, go to RUN; busy falls on that same edge.
  - Sweep length is exactly DEPTH cycles after reset release.
  - ready_a and ready_b are low; requests are ignored and not queued.
- RUN: clear_req=1 moves to CLEAR with clr_addr=0; busy rises next cycle. clear_req is ignored while already in CLEAR.
- Transfer: a transfer occurs when req_x and ready_x are both high at the rising edge.
- Write: mem[addr_x] <= data_x at that edge; no rvalid is produced.
- Read latency 1: q_x <= mem[addr_x] and rvalid_x=1 on the accepting edge; rvalid_x clears on the next edge unless another read is accepted.
- q_x holds its last value when no read is accepted.
- Read accepted in the same cycle as clear_req completes normally.
- Both ports write the same address in the same cycle: port A's data is stored, port B's is dropped, collision=1 for one cycle. Different addresses: both writes commit.
- One port reads while the other writes the same address: read-before-write, so the reader gets the old data.
- Both ports read the same address: both get the same data.
- Address wraps naturally; out-of-range addresses are impossible because DEPTH = 2**ADDR_W.

Optional Feature:
- Macro: GAME_MEM_COLLISION_CNT_EN.
- Defined:
  - Adds output collision_cnt [15:0], incremented on each collision pulse.
  - Saturates at 16'hFFFF.
  - Cleared by reset and by entry into CLEAR.
- Undefined: the port and counter are absent; the collision pulse is unchanged.

Decomposition:
- Package game_mem_pkg holds:
  - state encoding constants ST_CLEAR and ST_RUN;
  - default DATA_W/ADDR_W values;
  - collision counter width (16).
- Sub-module game_board_ram_dp:
  - Inferred true dual-port array with registered outputs and read-before-write.
  - The port A write-priority mux lives in it.
- The top level holds the FSM, clear counter, handshake, rvalid and collision logic.

Test Plan:
- Reset release with ADDR_W=4 -> busy=1 for exactly 16 cycles, ready_a=ready_b=0 throughout; then a read of any address returns INIT_VALUE with rvalid_a one cycle after accept.
- Port A writes 32'hDEADBEEF @0x10, then reads 0x10 -> q_a=32'hDEADBEEF, rvalid_a one-cycle pulse at accept+1.
- Same cycle: A writes 32'h1 @0x20 and B writes 32'h2 @0x20 -> collision=1 for one cycle; a later read returns 32'h1.
- mem[0x30]=32'h5; same cycle: A writes 32'h7 @0x30 and B reads 0x30 -> q_b=32'h5; a next B read returns 32'h7.
- clear_req after writes -> busy high for DEPTH cycles, requests ignored; afterwards all locations read INIT_VALUE.
- resetn asserted low mid-sweep at clr_addr=5 -> outputs return to reset values immediately; sweep restarts from address 0 on release.
